// File: rtl/chaos_map_pkg.sv
// rtl/chaos_map_pkg.sv - shared chaos-map constants: sequencer state encoding and default operand width
package chaos_map_pkg;

  // Default operand width of the fixed-point multiplier used by the logistic map.
  localparam int SEQ_MULT_WIDTH = 18;

  // Sequencer state encoding, shared with the logistic function sequencers.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to count 0..w inclusive.
  function automatic int count_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult18.sv
// rtl/seq_mult18.sv - radix-2 shift-add sequential unsigned multiplier with 4-phase start/done handshake
module seq_mult18
  import chaos_map_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 calc_start,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done
);

  localparam int              CW   = count_bits(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]           state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplr;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc_next;

  // The single adder: accumulate the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_next = acc;
    if (mplr[0]) acc_next = acc + mcand;
  end

  // Handshake sequencer and shift-add datapath; a full run is always WIDTH steps, no early exit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
      result <= '0;
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (calc_start) begin
            mcand <= {{WIDTH{1'b0}}, dataa};
            mplr  <= datab;
            acc   <= '0;
            count <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!calc_start) begin
            // Initiator withdrew the request: abandon the product, keep the old result.
            done  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            count <= count + CW'(1);
            if (count == LAST) begin
              result <= acc_next;
              done   <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Hold the result until the initiator drops its request; no retrigger from here.
          if (!calc_start) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult18.sv
// tb/tb_seq_mult18.sv - table-driven self-checking bench for seq_mult18
module tb_seq_mult18;

  logic        CLK;
  logic        RST;
  logic        calc_start;
  logic [17:0] dataa;
  logic [17:0] datab;
  logic [35:0] result;
  logic        done;

  int errors = 0;
  int checks = 0;

  seq_mult18 dut (
    .CLK        (CLK),
    .RST        (RST),
    .calc_start (calc_start),
    .dataa      (dataa),
    .datab      (datab),
    .result     (result),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [35:0] p;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One complete handshake; operands are scrambled right after capture to prove they are ignored.
  task automatic run_op(input logic [17:0] a, input logic [17:0] b, input logic [35:0] exp,
                        input string nm);
    int lat;
    @(negedge CLK);
    calc_start = 1'b1;
    dataa = a;
    datab = b;
    @(posedge CLK);
    #1;
    chk({nm, " done_after_capture"}, 64'(done), 64'd0);
    @(negedge CLK);
    dataa = ~a;
    datab = ~b;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({nm, " latency"}, 64'(lat), 64'd18);
    chk({nm, " result"}, 64'(result), 64'(exp));
    repeat (3) @(posedge CLK);
    #1;
    chk({nm, " done_held"}, 64'(done), 64'd1);
    chk({nm, " result_held"}, 64'(result), 64'(exp));
    @(negedge CLK);
    calc_start = 1'b0;
    @(posedge CLK);
    #1;
    chk({nm, " done_cleared"}, 64'(done), 64'd0);
    chk({nm, " result_retained"}, 64'(result), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hung expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit saw_done;

    vecs[0] = '{a: 18'd3,       b: 18'd5,       p: 36'd15};
    vecs[1] = '{a: 18'h3FFFF,   b: 18'h3FFFF,   p: 36'hFFFF80001};
    vecs[2] = '{a: 18'h10000,   b: 18'h0FFFF,   p: 36'h0FFFF0000};
    vecs[3] = '{a: 18'h10000,   b: 18'h00000,   p: 36'h000000000};
    vecs[4] = '{a: 18'd1,       b: 18'd1,       p: 36'd1};
    vecs[5] = '{a: 18'h3FFFF,   b: 18'd1,       p: 36'h00003FFFF};
    vecs[6] = '{a: 18'd1000,    b: 18'd250,     p: 36'd250000};

    RST = 1'b0;
    calc_start = 1'b0;
    dataa = '0;
    datab = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Abort: request dropped so that the 5th RUN edge sees calc_start=0.
    @(negedge CLK);
    calc_start = 1'b1;
    dataa = 18'h55;
    datab = 18'd3;
    @(posedge CLK);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    calc_start = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge CLK);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort no_done", 64'(saw_done), 64'd0);
    chk("abort result_held", 64'(result), 64'd250000);
    run_op(18'd7, 18'd9, 36'd63, "after_abort");

    // Operands forced to all-ones before RUN edge 3 of a 2*2 operation.
    @(negedge CLK);
    calc_start = 1'b1;
    dataa = 18'd2;
    datab = 18'd2;
    @(posedge CLK);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    dataa = 18'h3FFFF;
    datab = 18'h3FFFF;
    lat = 0;
    for (int i = 3; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("opchange latency", 64'(lat), 64'd18);
    chk("opchange result", 64'(result), 64'd4);
    @(negedge CLK);
    calc_start = 1'b0;
    @(posedge CLK);

    // Asynchronous reset in the middle of RUN edge 10.
    @(negedge CLK);
    calc_start = 1'b1;
    dataa = 18'd5;
    datab = 18'd5;
    @(posedge CLK);
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst done", 64'(done), 64'd0);
    chk("async_rst result", 64'(result), 64'd0);
    @(negedge CLK);
    calc_start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (25) @(posedge CLK);
    #1;
    chk("post_rst idle done", 64'(done), 64'd0);
    chk("post_rst idle result", 64'(result), 64'd0);
    run_op(18'd6, 18'd7, 36'd42, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult18.md
SEQ_MULT18 -- requirements
Module: seq_mult18

Interface
REQ-001 SHALL have parameter WIDTH, default 18, operand width in bits; result is 2*WIDTH bits.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-003 SHALL have port CLK  input  1  rising-edge clock, which is the fast calculation clock.
REQ-004 SHALL have port RST  input  1  asynchronous active-low reset.
REQ-005 SHALL have port calc_start  input  1  level request from the initiator (4-phase handshake).
REQ-006 SHALL have port dataa  input  WIDTH  unsigned multiplicand.
REQ-007 SHALL have port datab  input  WIDTH  unsigned multiplier.
REQ-008 SHALL have port result  output  2*WIDTH  registered unsigned product dataa*datab.
REQ-009 SHALL have port done  output  1  registered completion flag; high means result is valid.

Function
REQ-010 SHALL implement states IDLE, RUN, DONE.
REQ-011 IDLE: done=0; on an edge with calc_start=1, SHALL capture dataa/datab into internal registers, clear the accumulator, set iteration count=0, and go to RUN.
REQ-012 RUN: each edge SHALL perform one radix-2 shift-add step: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator; shift the multiplicand left and the multiplier right; increment count.
REQ-013 SHALL take exactly WIDTH RUN edges after the capture edge; on the WIDTH-th RUN edge it SHALL load result with the exact 2*WIDTH-bit product, set done=1 and go to DONE (latency 18 edges capture-to-done at default).
REQ-014 Latency SHALL be fixed and independent of operand values, with no early termination on zero operands.
REQ-015 DONE: SHALL hold done=1 and result stable while calc_start=1.
REQ-016 DONE: on an edge with calc_start=0, SHALL clear done and go to IDLE; result SHALL retain its value.
REQ-017 A new operation SHALL start only from IDLE; calc_start held high across DONE SHALL NOT retrigger.
REQ-018 Abort: calc_start=0 on any RUN edge SHALL return to IDLE with done=0 and result unchanged.
REQ-019 Operand inputs SHALL be ignored outside the capture edge; changes during RUN/DONE SHALL NOT affect result.
REQ-020 Accumulator width SHALL be 2*WIDTH with no overflow; (2^WIDTH-1)^2 SHALL be representable.
REQ-021 calc_start is synchronous to CLK; the block SHALL NOT synchronise it.

Reset
REQ-022 RST=0 SHALL immediately force state=IDLE, done=0, result=0, and clear the accumulator, operand registers and count, regardless of CLK.
REQ-023 Reset mid-RUN or mid-DONE SHALL discard the operation; after release the block SHALL wait in IDLE for calc_start=1.
REQ-024 On the first edge after release with calc_start=1, the block SHALL capture operands normally.

Structure
REQ-025 The state encoding and the WIDTH default SHALL live in the shared chaos-map package/header, reused by the logistic function sequencers.
REQ-026 SHALL be a single module with no sub-module; the datapath is one adder, two shifters and a counter of ceil(log2(WIDTH+1)) bits.

Verification
REQ-027 dataa=3, datab=5, calc_start raised and held -> done rises exactly 18 edges after capture, result=15; calc_start dropped -> done=0 next edge.
REQ-028 dataa=0x3FFFF, datab=0x3FFFF -> result=0xFFFF80001 after 18 edges.
REQ-029 dataa=0x10000, datab=0x0FFFF (logistic x*(1-x) case) -> result=0x0FFFF0000; datab=0 -> result=0 with the full 18-edge latency.
REQ-030 Abort: calc_start dropped on the 5th RUN edge -> done never rises and the prior result is held; next request 7*9 -> 63.
REQ-031 Operands changed to 0x3FFFF on RUN edge 3 of a 2*2 operation -> result=4.
REQ-032 RST pulsed low asynchronously during RUN edge 10 -> done=0 and result=0 immediately; after release, 6*7 -> 42 with 18-edge latency.
